// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants, control-bundle bit map and FSM encoding for pipe_ctrl_unit
package pipe_ctrl_pkg;

    localparam logic [4:0] OP_RTYPE = 5'd0;
    localparam logic [4:0] OP_J     = 5'd1;
    localparam logic [4:0] OP_BNE   = 5'd2;
    localparam logic [4:0] OP_JAL   = 5'd3;
    localparam logic [4:0] OP_JR    = 5'd4;
    localparam logic [4:0] OP_ADDI  = 5'd5;
    localparam logic [4:0] OP_BLT   = 5'd6;
    localparam logic [4:0] OP_SW    = 5'd7;
    localparam logic [4:0] OP_LW    = 5'd8;

    localparam logic [4:0] ALUOP_MUL = 5'b00110;
    localparam logic [4:0] ALUOP_DIV = 5'b00111;

    // Single-bit flags occupy [10:0]; the ALU op field sits above them.
    localparam int B_ALU_INB  = 0;
    localparam int B_DM_WE    = 1;
    localparam int B_RF_WE    = 2;
    localparam int B_RTAR     = 3;
    localparam int B_RWD      = 4;
    localparam int B_JP       = 5;
    localparam int B_BNE      = 6;
    localparam int B_BLT      = 7;
    localparam int B_JAL      = 8;
    localparam int B_JR       = 9;
    localparam int B_MD_START = 10;
    localparam int ALUOP_LSB  = 11;
    localparam int ALUOP_BITS = 5;
    localparam int CTRLW      = ALUOP_LSB + ALUOP_BITS;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// rtl/pipe_ctrl_unit_decode.sv - combinational opcode/aluop decode into the packed control bundle
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int OPW    = 5,
    parameter int ALUOPW = 5,
    parameter int REGW   = 5
) (
    input  logic [OPW-1:0]    opcode,
    input  logic [ALUOPW-1:0] aluop,
    input  logic [REGW-1:0]   rd,
    output logic [CTRLW-1:0]  ctrl,
    output logic [REGW-1:0]   dest,
    output logic              src2_used
);

    logic is_md;

    assign is_md = (aluop == ALUOPW'(ALUOP_MUL)) || (aluop == ALUOPW'(ALUOP_DIV));

    always_comb begin
        ctrl      = '0;
        dest      = rd;
        src2_used = 1'b1;
        case (opcode)
            OPW'(OP_RTYPE): begin
                ctrl[B_RF_WE]                       = !is_md;
                ctrl[B_MD_START]                    = is_md;
                ctrl[ALUOP_LSB +: ALUOP_BITS]       = ALUOP_BITS'(aluop);
            end
            OPW'(OP_J): begin
                ctrl[B_JP] = 1'b1;
                src2_used  = 1'b0;
            end
            OPW'(OP_BNE): begin
                ctrl[B_RTAR] = 1'b1;
                ctrl[B_BNE]  = 1'b1;
            end
            OPW'(OP_JAL): begin
                ctrl[B_RF_WE] = 1'b1;
                ctrl[B_JP]    = 1'b1;
                ctrl[B_JAL]   = 1'b1;
                dest          = REGW'(31);
                src2_used     = 1'b0;
            end
            OPW'(OP_JR): begin
                ctrl[B_RTAR] = 1'b1;
                ctrl[B_JR]   = 1'b1;
            end
            OPW'(OP_ADDI): begin
                ctrl[B_ALU_INB] = 1'b1;
                ctrl[B_RF_WE]   = 1'b1;
                src2_used       = 1'b0;
            end
            OPW'(OP_BLT): begin
                ctrl[B_RTAR] = 1'b1;
                ctrl[B_BLT]  = 1'b1;
            end
            OPW'(OP_SW): begin
                ctrl[B_ALU_INB] = 1'b1;
                ctrl[B_DM_WE]   = 1'b1;
                ctrl[B_RTAR]    = 1'b1;
            end
            OPW'(OP_LW): begin
                ctrl[B_ALU_INB] = 1'b1;
                ctrl[B_RF_WE]   = 1'b1;
                ctrl[B_RWD]     = 1'b1;
                src2_used       = 1'b0;
            end
            default: ;
        endcase
        // r0 is hardwired, so never let a write to it reach the register file.
        if (dest == '0) ctrl[B_RF_WE] = 1'b0;
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - ID/EX control register with load-use stall, flush, MUL/DIV sequencer and stall counter
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int OPW    = 5,
    parameter int ALUOPW = 5,
    parameter int REGW   = 5,
    parameter int MD_LAT = 32,
    parameter int CNTW   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [OPW-1:0]    id_opcode,
    input  logic [ALUOPW-1:0] id_aluop,
    input  logic [REGW-1:0]   id_rd,
    input  logic [REGW-1:0]   id_rs,
    input  logic [REGW-1:0]   id_rt,
    input  logic              flush,
    output logic              ex_valid,
    output logic [CTRLW-1:0]  ex_ctrl,
    output logic [REGW-1:0]   ex_rd,
    output logic              md_busy,
    output logic              md_wb,
    output logic [REGW-1:0]   md_rd,
    output logic [CNTW-1:0]   stall_cnt
);

    localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam logic [CW-1:0] MD_LAST = CW'(MD_LAT - 1);

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [CTRLW-1:0] dec_ctrl;
    logic [REGW-1:0] dec_dest;
    logic            src2_used;
    logic [REGW-1:0] src2;
    logic            load_use;
    logic            issue;
    logic            md_issue;

    ctrl_decode #(
        .OPW    (OPW),
        .ALUOPW (ALUOPW),
        .REGW   (REGW)
    ) u_decode (
        .opcode    (id_opcode),
        .aluop     (id_aluop),
        .rd        (id_rd),
        .ctrl      (dec_ctrl),
        .dest      (dec_dest),
        .src2_used (src2_used)
    );

    assign src2     = dec_ctrl[B_RTAR] ? id_rd : id_rt;
    assign load_use = ex_valid && ex_ctrl[B_RWD] && (ex_rd != '0) &&
                      ((id_rs == ex_rd) || (src2_used && (src2 == ex_rd)));
    assign id_ready = (state == ST_RUN) && !load_use;
    // A flushed transfer is discarded entirely, including any MUL/DIV it would start.
    assign issue    = id_valid && id_ready && !flush;
    assign md_issue = issue && dec_ctrl[B_MD_START];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        md_busy    = 1'b0;
        md_wb      = 1'b0;
        case (state)
            ST_RUN: begin
                if (md_issue) begin
                    state_next = ST_MD_BUSY;
                    cnt_next   = MD_LAST;
                end
            end
            ST_MD_BUSY: begin
                md_busy = 1'b1;
                if (cnt == '0) begin
                    md_wb      = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_RUN;
            cnt       <= '0;
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_rd     <= '0;
            md_rd     <= '0;
            stall_cnt <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            ex_valid <= issue;
            ex_ctrl  <= issue ? dec_ctrl : '0;
            ex_rd    <= issue ? dec_dest : '0;
            if (md_issue) md_rd <= dec_dest;
            if (id_valid && !id_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - directed self-checking bench for pipe_ctrl_unit
module tb_pipe_ctrl_unit;
    import pipe_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_opcode, id_aluop, id_rd, id_rs, id_rt;
    logic        flush;

    logic        a_id_ready, a_ex_valid, a_md_busy, a_md_wb;
    logic [15:0] a_ex_ctrl;
    logic [4:0]  a_ex_rd, a_md_rd;
    logic [15:0] a_stall_cnt;

    logic        b_id_ready, b_ex_valid, b_md_busy, b_md_wb;
    logic [15:0] b_ex_ctrl;
    logic [4:0]  b_ex_rd, b_md_rd;
    logic [1:0]  b_stall_cnt;

    logic        c_id_ready, c_ex_valid, c_md_busy, c_md_wb;
    logic [15:0] c_ex_ctrl;
    logic [4:0]  c_ex_rd, c_md_rd;
    logic [15:0] c_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipe_ctrl_unit #(.MD_LAT(4), .CNTW(16)) u_a (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_ready(a_id_ready),
        .id_opcode(id_opcode), .id_aluop(id_aluop), .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
        .flush(flush), .ex_valid(a_ex_valid), .ex_ctrl(a_ex_ctrl), .ex_rd(a_ex_rd),
        .md_busy(a_md_busy), .md_wb(a_md_wb), .md_rd(a_md_rd), .stall_cnt(a_stall_cnt)
    );

    pipe_ctrl_unit #(.MD_LAT(8), .CNTW(2)) u_b (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_ready(b_id_ready),
        .id_opcode(id_opcode), .id_aluop(id_aluop), .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
        .flush(flush), .ex_valid(b_ex_valid), .ex_ctrl(b_ex_ctrl), .ex_rd(b_ex_rd),
        .md_busy(b_md_busy), .md_wb(b_md_wb), .md_rd(b_md_rd), .stall_cnt(b_stall_cnt)
    );

    pipe_ctrl_unit #(.MD_LAT(1), .CNTW(16)) u_c (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_ready(c_id_ready),
        .id_opcode(id_opcode), .id_aluop(id_aluop), .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt),
        .flush(flush), .ex_valid(c_ex_valid), .ex_ctrl(c_ex_ctrl), .ex_rd(c_ex_rd),
        .md_busy(c_md_busy), .md_wb(c_md_wb), .md_rd(c_md_rd), .stall_cnt(c_stall_cnt)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_instr(input logic [4:0] op, input logic [4:0] alu,
                             input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        id_valid  = 1'b1;
        id_opcode = op;
        id_aluop  = alu;
        id_rd     = rd;
        id_rs     = rs;
        id_rt     = rt;
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        id_valid = 1'b0;
        flush    = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        flush = 1'b0;
        set_instr(5'd5, 5'd0, 5'd3, 5'd1, 5'd2);
        tick();
        tick();
        checks++;
        if ({a_ex_valid, a_ex_ctrl, a_ex_rd, a_md_busy, a_md_wb, a_md_rd, a_stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ev=%0b ctrl=%h rd=%0d busy=%0b wb=%0b mdrd=%0d stall=%0d required all 0",
                     a_ex_valid, a_ex_ctrl, a_ex_rd, a_md_busy, a_md_wb, a_md_rd, a_stall_cnt);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (a_ex_valid !== 1'b1 || a_ex_ctrl !== 16'h0005 || a_ex_rd !== 5'd3) begin
            errors++;
            $display("FAIL addi_issue got ev=%0b ctrl=%h rd=%0d required ev=1 ctrl=0005 rd=3",
                     a_ex_valid, a_ex_ctrl, a_ex_rd);
        end
        id_valid = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        set_instr(5'd8, 5'd0, 5'd5, 5'd1, 5'd0);
        tick();
        set_instr(5'd0, 5'd0, 5'd6, 5'd5, 5'd2);
        checks++;
        if (a_id_ready !== 1'b0) begin
            errors++;
            $display("FAIL lu_ready_low got %0b required 0", a_id_ready);
        end
        tick();
        checks++;
        if (a_ex_valid !== 1'b0 || a_stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL lu_bubble got ev=%0b stall=%0d required ev=0 stall=1", a_ex_valid, a_stall_cnt);
        end
        tick();
        checks++;
        if (a_ex_valid !== 1'b1 || a_ex_rd !== 5'd6 || a_ex_ctrl !== 16'h0004) begin
            errors++;
            $display("FAIL lu_add_issue got ev=%0b rd=%0d ctrl=%h required ev=1 rd=6 ctrl=0004",
                     a_ex_valid, a_ex_rd, a_ex_ctrl);
        end
        // rt match stalls an R-type; addi ignores rt
        set_instr(5'd8, 5'd0, 5'd5, 5'd1, 5'd0);
        tick();
        set_instr(5'd0, 5'd0, 5'd6, 5'd1, 5'd5);
        checks++;
        if (a_id_ready !== 1'b0) begin
            errors++;
            $display("FAIL lu_rt_stall got ready=%0b required 0", a_id_ready);
        end
        set_instr(5'd5, 5'd0, 5'd6, 5'd1, 5'd5);
        checks++;
        if (a_id_ready !== 1'b1) begin
            errors++;
            $display("FAIL lu_addi_rt_nostall got ready=%0b required 1", a_id_ready);
        end
        do_reset();
        set_instr(5'd8, 5'd0, 5'd0, 5'd1, 5'd0);
        tick();
        set_instr(5'd0, 5'd0, 5'd6, 5'd0, 5'd2);
        checks++;
        if (a_id_ready !== 1'b1) begin
            errors++;
            $display("FAIL lu_r0_ready got %0b required 1", a_id_ready);
        end
        tick();
        checks++;
        if (a_ex_valid !== 1'b1 || a_stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL lu_r0_nostall got ev=%0b stall=%0d required ev=1 stall=0", a_ex_valid, a_stall_cnt);
        end
        id_valid = 1'b0;
    endtask

    task automatic test_mul();
        do_reset();
        set_instr(5'd0, 5'b00110, 5'd7, 5'd1, 5'd2);
        tick();
        checks++;
        if (a_ex_valid !== 1'b1 || a_ex_ctrl !== 16'h3400 || a_md_rd !== 5'd7) begin
            errors++;
            $display("FAIL mul_issue got ev=%0b ctrl=%h mdrd=%0d required ev=1 ctrl=3400 mdrd=7",
                     a_ex_valid, a_ex_ctrl, a_md_rd);
        end
        set_instr(5'd5, 5'd0, 5'd3, 5'd1, 5'd2);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (a_md_busy !== 1'b1 || a_id_ready !== 1'b0 || a_md_wb !== (k == 4)) begin
                errors++;
                $display("FAIL mul_busy_%0d got busy=%0b ready=%0b wb=%0b required busy=1 ready=0 wb=%0b",
                         k, a_md_busy, a_id_ready, a_md_wb, (k == 4));
            end
            if (k == 2) begin
                checks++;
                if (a_ex_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL mul_ex_bubble got %0b required 0", a_ex_valid);
                end
            end
            tick();
        end
        checks++;
        if (a_md_busy !== 1'b0 || a_md_wb !== 1'b0 || a_id_ready !== 1'b1 || a_stall_cnt !== 16'd4) begin
            errors++;
            $display("FAIL mul_done got busy=%0b wb=%0b ready=%0b stall=%0d required busy=0 wb=0 ready=1 stall=4",
                     a_md_busy, a_md_wb, a_id_ready, a_stall_cnt);
        end
        tick();
        checks++;
        if (a_ex_valid !== 1'b1 || a_ex_rd !== 5'd3) begin
            errors++;
            $display("FAIL mul_next_issue got ev=%0b rd=%0d required ev=1 rd=3", a_ex_valid, a_ex_rd);
        end
        id_valid = 1'b0;
    endtask

    task automatic test_flush();
        bit seen_wb;
        do_reset();
        set_instr(5'd7, 5'd0, 5'd4, 5'd1, 5'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        id_valid = 1'b0;
        checks++;
        if (a_ex_valid !== 1'b0 || a_ex_ctrl[B_DM_WE] !== 1'b0) begin
            errors++;
            $display("FAIL flush_sw got ev=%0b dm_we=%0b required ev=0 dm_we=0", a_ex_valid, a_ex_ctrl[B_DM_WE]);
        end
        set_instr(5'd0, 5'b00111, 5'd7, 5'd1, 5'd2);
        tick();
        id_valid = 1'b0;
        flush = 1'b1;
        seen_wb = 1'b0;
        for (int k = 0; k < 10 && !seen_wb; k++) begin
            #1;
            if (a_md_wb === 1'b1 && a_md_rd === 5'd7) seen_wb = 1'b1;
            tick();
        end
        flush = 1'b0;
        checks++;
        if (seen_wb !== 1'b1) begin
            errors++;
            $display("FAIL flush_md_wb got seen=%0b required 1", seen_wb);
        end
    endtask

    task automatic test_jal_and_r0();
        do_reset();
        set_instr(5'd3, 5'd0, 5'd9, 5'd1, 5'd2);
        tick();
        checks++;
        if (a_ex_valid !== 1'b1 || a_ex_rd !== 5'd31 || a_ex_ctrl !== 16'h0124) begin
            errors++;
            $display("FAIL jal got ev=%0b rd=%0d ctrl=%h required ev=1 rd=31 ctrl=0124",
                     a_ex_valid, a_ex_rd, a_ex_ctrl);
        end
        set_instr(5'd0, 5'd0, 5'd0, 5'd1, 5'd2);
        tick();
        checks++;
        if (a_ex_valid !== 1'b1 || a_ex_ctrl !== 16'h0000) begin
            errors++;
            $display("FAIL add_r0 got ev=%0b ctrl=%h required ev=1 ctrl=0000", a_ex_valid, a_ex_ctrl);
        end
        set_instr(5'd20, 5'd3, 5'd3, 5'd1, 5'd2);
        tick();
        checks++;
        if (a_ex_valid !== 1'b1 || a_ex_ctrl !== 16'h0000 || a_ex_rd !== 5'd3) begin
            errors++;
            $display("FAIL nop_opcode got ev=%0b ctrl=%h rd=%0d required ev=1 ctrl=0000 rd=3",
                     a_ex_valid, a_ex_ctrl, a_ex_rd);
        end
        id_valid = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        set_instr(5'd0, 5'b00110, 5'd7, 5'd1, 5'd2);
        tick();
        set_instr(5'd5, 5'd0, 5'd3, 5'd1, 5'd2);
        for (int k = 0; k < 6; k++) tick();
        checks++;
        if (b_stall_cnt !== 2'd3 || b_md_busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_saturate got stall=%0d busy=%0b required stall=3 busy=1", b_stall_cnt, b_md_busy);
        end
        id_valid = 1'b0;
    endtask

    task automatic test_reset_mid_md();
        bit seen_wb;
        do_reset();
        set_instr(5'd0, 5'b00110, 5'd7, 5'd1, 5'd2);
        tick();
        id_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (a_md_busy !== 1'b0 || a_md_wb !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_md got busy=%0b wb=%0b required 0 0", a_md_busy, a_md_wb);
        end
        reset = 1'b1;
        seen_wb = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (a_md_wb === 1'b1) seen_wb = 1'b1;
            tick();
        end
        checks++;
        if (seen_wb !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_md_no_wb got seen=%0b required 0", seen_wb);
        end
    endtask

    task automatic test_md_lat1();
        do_reset();
        set_instr(5'd0, 5'b00110, 5'd7, 5'd1, 5'd2);
        tick();
        id_valid = 1'b0;
        checks++;
        if (c_md_busy !== 1'b1 || c_md_wb !== 1'b1 || c_md_rd !== 5'd7) begin
            errors++;
            $display("FAIL lat1_wb got busy=%0b wb=%0b mdrd=%0d required 1 1 7", c_md_busy, c_md_wb, c_md_rd);
        end
        tick();
        checks++;
        if (c_md_busy !== 1'b0 || c_md_wb !== 1'b0 || c_id_ready !== 1'b1) begin
            errors++;
            $display("FAIL lat1_done got busy=%0b wb=%0b ready=%0b required 0 0 1", c_md_busy, c_md_wb, c_id_ready);
        end
    endtask

    initial begin
        reset     = 1'b0;
        id_valid  = 1'b0;
        flush     = 1'b0;
        id_opcode = '0;
        id_aluop  = '0;
        id_rd     = '0;
        id_rs     = '0;
        id_rt     = '0;
        test_reset();
        test_load_use();
        test_mul();
        test_flush();
        test_jal_and_r0();
        test_saturate();
        test_reset_mid_md();
        test_md_lat1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
